// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/WB/HALT with gated
// strobes and a retired-instruction counter.
module mc_sequencer #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WORD_SIZE-1:0] instr,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 reg_write,
  output logic                 reg_dst_rd,
  output logic                 alu_src_imm,
  output logic [1:0]           alu_op,
  output logic                 wwd_valid,
  output logic                 illegal,
  output logic                 halted,
  output logic [WORD_SIZE-1:0] num_inst
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    K_ADD,
    K_ADI,
    K_LHI
  } kind_t;

  state_t state_q, state_d;
  kind_t  kind_q, kind_d;
  logic [WORD_SIZE-1:0] cnt_q;
  logic inc;
  logic go;

  logic [3:0] op;
  logic [5:0] fn;
  logic is_add, is_adi, is_lhi;
  logic is_jmp, is_wwd, is_hlt;

  assign op = instr[15:12];
  assign fn = instr[5:0];

  assign is_add = (op == 4'hF) && (fn == 6'd0);
  assign is_adi = (op == 4'h4);
  assign is_lhi = (op == 4'h6);
  assign is_jmp = (op == 4'h9);
  assign is_wwd = (op == 4'hF) && (fn == 6'd28);
  assign is_hlt = (op == 4'hF) && (fn == 6'd29);

  // Every strobe and every transition is qualified by go.
  assign go = enable && !reset;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    inc         = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    reg_dst_rd  = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = 2'b00;
    wwd_valid   = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_write = go;
        pc_write = go;
        if (go) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_add: begin
            if (go) begin
              kind_d  = K_ADD;
              state_d = S_EXEC;
            end
          end
          is_adi: begin
            if (go) begin
              kind_d  = K_ADI;
              state_d = S_EXEC;
            end
          end
          is_lhi: begin
            if (go) begin
              kind_d  = K_LHI;
              state_d = S_EXEC;
            end
          end
          is_jmp: begin
            pc_src   = 1'b1;
            pc_write = go;
            inc      = go;
            if (go) state_d = S_FETCH;
          end
          is_wwd: begin
            wwd_valid = go;
            inc       = go;
            if (go) state_d = S_FETCH;
          end
          is_hlt: begin
            inc = go;
            if (go) state_d = S_HALT;
          end
          default: begin
            illegal = go;
            if (go) state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC, S_WB: begin
        reg_dst_rd  = (kind_q == K_ADD);
        alu_src_imm = (kind_q != K_ADD);
        alu_op      = (kind_q == K_LHI) ? 2'b01 : 2'b00;
        if (state_q == S_WB) begin
          reg_write = go;
          inc       = go;
          if (go) state_d = S_FETCH;
        end else if (go) begin
          state_d = S_WB;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      kind_q  <= K_ADD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      if (inc) cnt_q <= cnt_q + WORD_SIZE'(1);
    end
  end

  assign num_inst = cnt_q;

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, instruction/counter width.
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1  advance permission; low freezes state, counter and all strobes.
REQ-005 SHALL have port instr  input  WORD_SIZE  current instruction register contents (opcode [15:12], func [5:0]).
REQ-006 SHALL have port ir_write  output  1  load instruction register.
REQ-007 SHALL have port pc_write  output  1  load program counter.
REQ-008 SHALL have port pc_src  output  1  0 = PC+1, 1 = jump target {PC[15:12], instr[11:0]}.
REQ-009 SHALL have port reg_write  output  1  register file write strobe.
REQ-010 SHALL have port reg_dst_rd  output  1  1 = write instr[7:6] (rd), 0 = instr[9:8] (rt).
REQ-011 SHALL have port alu_src_imm  output  1  1 = sign-extended instr[7:0] as ALU operand B.
REQ-012 SHALL have port alu_op  output  2  00 ADD, 01 LHI ({imm, 8'h00}), others reserved.
REQ-013 SHALL have port wwd_valid  output  1  one-cycle pulse: output port loads rs value.
REQ-014 SHALL have port illegal  output  1  one-cycle pulse on unrecognised instruction.
REQ-015 SHALL have port halted  output  1  high while in HALT.
REQ-016 SHALL have port num_inst  output  WORD_SIZE  retired-instruction count.

Function
REQ-017 SHALL implement states FETCH, DECODE, EXEC, WB, HALT.
REQ-018 FETCH SHALL assert ir_write, pc_write, pc_src=0 for one cycle, then go to DECODE.
REQ-019 DECODE SHALL decode: ADD (op 15, func 0), ADI (op 4), LHI (op 6), JMP (op 9), WWD (op 15, func 28), HLT (op 15, func 29).
REQ-020 DECODE with ADD/ADI/LHI SHALL go to EXEC; EXEC SHALL go to WB; WB SHALL assert reg_write and go to FETCH.
REQ-021 ADD SHALL drive alu_src_imm=0, reg_dst_rd=1, alu_op=00; ADI alu_src_imm=1, reg_dst_rd=0, alu_op=00; LHI alu_src_imm=1, reg_dst_rd=0, alu_op=01; held through EXEC and WB.
REQ-022 DECODE with JMP SHALL assert pc_write, pc_src=1 and go to FETCH.
REQ-023 DECODE with WWD SHALL pulse wwd_valid and go to FETCH.
REQ-024 DECODE with HLT SHALL go to HALT; HALT SHALL be left only by reset.
REQ-025 DECODE with any other encoding SHALL pulse illegal, not count, and go to FETCH.
REQ-026 num_inst SHALL increment by 1 in the cycle of WB, JMP-DECODE, WWD-DECODE, HLT-DECODE; wraps 16'hFFFF -> 0.
REQ-027 Latency SHALL be ALU ops 4 cycles, JMP/WWD/HLT 2 cycles, fetch-to-fetch.
REQ-028 ir_write, pc_write, reg_write, wwd_valid, illegal SHALL be 0 whenever enable=0 or reset=1.
REQ-029 enable=0 in any state SHALL hold state and num_inst; on enable=1 the held state's action executes exactly once.
REQ-030 Non-strobe outputs (pc_src, reg_dst_rd, alu_src_imm, alu_op) SHALL be 0 outside their defined states.

Reset
REQ-031 reset=1 at a rising edge SHALL set state FETCH and num_inst 0, overriding enable.
REQ-032 reset mid-instruction (any state incl. HALT) SHALL abandon it with no register write or count.
REQ-033 After reset release the first enabled cycle SHALL be FETCH with ir_write=1.

Verification
REQ-034 Reset, enable=1, instr=16'h4204 (ADI) -> ir_write cycle 0, reg_write cycle 3 only, alu_src_imm=1, num_inst=1 after cycle 3.
REQ-035 instr=16'h9015 (JMP) -> cycle 1 pc_write=1, pc_src=1; num_inst +1; FETCH at cycle 2.
REQ-036 instr=16'hf01c (WWD) -> wwd_valid exactly one pulse in cycle 1; no reg_write.
REQ-037 ADD 16'hf6c0 with enable=0 for 3 cycles during WB -> reg_write 0 while stalled, exactly one reg_write cycle after resume, num_inst +1.
REQ-038 instr=16'hf01d (HLT) -> halted=1 from cycle 2, no strobes for 10 cycles; reset -> halted=0, num_inst=0, FETCH.
REQ-039 instr=16'h1000 -> illegal one pulse, num_inst unchanged; num_inst preloaded to 16'hFFFF by 65535 WWDs then one more -> 0.
